addr_decoder_slave_responder: RTL and testbench

- Register-file slave that sits on one select line of the unit address decoder's slave-side bus.
- Consumes the decoder outputs: per-slave select enable, write/read strobe, address and write data.
- Returns a one-bit acknowledge plus 8-bit read data after a programmable number of wait states.
- Four or five instances, one per select bit, form the synthesizable slave side of the decoder subsystem and close the loop in system-level tests.

---
 rtl/addr_decoder_slave_responder.sv | 124 ++++++++++++
 tb/tb_addr_decoder_slave_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/addr_decoder_slave_responder.sv
// Register-file slave on one select line of the address decoder's slave bus.
// A transfer is latched when the select goes high. After WAIT_STATES cycles
// the slave gives a one-cycle ack, with read data on reads. HOLD then
// blocks retriggering until the select drops.
module addr_decoder_slave_responder #(
  parameter int          SLAVE_ID    = 0,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 2,
  parameter logic [7:0]  RESET_VAL   = 8'h00,
  parameter logic [7:0]  OOR_DATA    = 8'hFF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [4:0] sel_en_in,
  input  logic       wr_rd_s_in,
  input  logic [7:0] addr_in,
  input  logic [7:0] wr_data_in,
  output logic       ack_out,
  output logic [7:0] rd_data_out,
  output logic       busy_out,
  output logic [7:0] xfer_cnt_out
);

  localparam int         IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0] NREG9 = 9'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  typedef struct packed {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  req_t       req_q;
  logic       start, do_ack;
  logic       sel;
  logic       in_range;
  logic [IDX_W-1:0] idx;
  logic [7:0] regs [NUM_REGS];

  // Only our own select bit matters; the rest of the bus is deliberately ignored.
  assign sel = sel_en_in[SLAVE_ID];
  logic unused_sel;
  assign unused_sel = ^sel_en_in;

  // The full 8-bit compare catches addresses that would alias in the low index bits.
  assign in_range = ({1'b0, req_q.addr} < NREG9);
  assign idx      = req_q.addr[IDX_W-1:0];

  // Next-state logic: start on select, count wait states, abort on drop, hold until release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start   = 1'b0;
    do_ack  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sel) begin
          start = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (!sel)               state_d = S_IDLE;
        else if (cnt_q == 4'd1) state_d = S_ACK;
        else                    cnt_d   = cnt_q - 4'd1;
      end
      S_ACK: begin
        do_ack  = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!sel) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, wait counter and the request latched at transfer start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) req_q <= '{wr: wr_rd_s_in, addr: addr_in, data: wr_data_in};
    end
  end

  // Register file: the write commits on the ack edge, so a later read sees the new value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
    end else if (do_ack && req_q.wr && in_range) begin
      regs[idx] <= req_q.data;
    end
  end

  // Registered outputs: ack pulse, read data only in a read-ack cycle, busy, transfer count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_out      <= 1'b0;
      rd_data_out  <= 8'h00;
      busy_out     <= 1'b0;
      xfer_cnt_out <= 8'h00;
    end else begin
      ack_out     <= do_ack;
      rd_data_out <= (do_ack && !req_q.wr) ? (in_range ? regs[idx] : OOR_DATA) : 8'h00;
      busy_out    <= (state_d != S_IDLE);
      if (do_ack) xfer_cnt_out <= xfer_cnt_out + 8'd1;
    end
  end

endmodule

// File: tb/tb_addr_decoder_slave_responder.sv
// Directed bench for addr_decoder_slave_responder (SLAVE_ID=0, 16 regs, 2 wait states).
module tb_addr_decoder_slave_responder;

  localparam int         SID = 0;
  localparam int         WS  = 2;
  localparam int         HK  = WS + 3;
  localparam logic [4:0] SEL = 5'(1 << SID);

  logic       clock = 1'b0;
  logic       reset_n;
  logic [4:0] sel_en_in;
  logic       wr_rd_s_in;
  logic [7:0] addr_in;
  logic [7:0] wr_data_in;
  logic       ack_out;
  logic [7:0] rd_data_out;
  logic       busy_out;
  logic [7:0] xfer_cnt_out;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_cnt = 8'h00;

  addr_decoder_slave_responder #(
    .SLAVE_ID(SID), .NUM_REGS(16), .WAIT_STATES(WS), .RESET_VAL(8'h00), .OOR_DATA(8'hFF)
  ) dut (
    .clock(clock), .reset_n(reset_n), .sel_en_in(sel_en_in), .wr_rd_s_in(wr_rd_s_in),
    .addr_in(addr_in), .wr_data_in(wr_data_in), .ack_out(ack_out),
    .rd_data_out(rd_data_out), .busy_out(busy_out), .xfer_cnt_out(xfer_cnt_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full transfer: select held 5 edges, inputs scrambled after the start edge.
  task automatic run_xfer(input logic wr, input logic [7:0] a, input logic [7:0] d,
                          input logic [7:0] exp_rd, input string tag);
    int         acks = 0;
    int         ack_k = -1;
    logic [7:0] rd_ack = 8'h00;
    logic       rd_bad = 1'b0;
    logic       busy_hi = 1'b0;
    logic       busy_lo = 1'b1;
    @(negedge clock);
    wr_rd_s_in = wr; addr_in = a; wr_data_in = d; sel_en_in = SEL;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (ack_out) begin
        acks++; ack_k = k; rd_ack = rd_data_out;
      end else if (rd_data_out !== 8'h00) begin
        rd_bad = 1'b1;
      end
      if (k == 1) begin
        wr_rd_s_in = ~wr; addr_in = ~a; wr_data_in = ~d;
      end
      if (k == HK) begin
        busy_hi = busy_out; sel_en_in = 5'b0;
      end
      if (k == HK + 1) busy_lo = busy_out;
    end
    exp_cnt = exp_cnt + 8'd1;
    chk({tag, " ack_count"}, acks, 1);
    chk({tag, " ack_latency"}, ack_k, WS + 2);
    chk({tag, " rd_data_at_ack"}, {24'h0, rd_ack}, wr ? 32'h0 : {24'h0, exp_rd});
    chk({tag, " rd_data_idle_zero"}, {31'h0, rd_bad}, 0);
    chk({tag, " busy_during"}, {31'h0, busy_hi}, 1);
    chk({tag, " busy_after_drop"}, {31'h0, busy_lo}, 0);
    chk({tag, " xfer_cnt"}, {24'h0, xfer_cnt_out}, {24'h0, exp_cnt});
  endtask

  // Watch for a number of cycles and report how many acks appeared.
  task automatic count_acks(input int cycles, output int acks, output int busies);
    acks = 0; busies = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if (ack_out) acks++;
      if (busy_out) busies++;
    end
  endtask

  initial begin
    int acks, busies;
    tbl[0]  = '{1'b1, 8'h03, 8'hA5, 8'h00};
    tbl[1]  = '{1'b0, 8'h03, 8'h00, 8'hA5};
    tbl[2]  = '{1'b0, 8'h07, 8'h00, 8'h00};
    tbl[3]  = '{1'b1, 8'h20, 8'h11, 8'h00};
    tbl[4]  = '{1'b0, 8'h20, 8'h00, 8'hFF};
    tbl[5]  = '{1'b0, 8'h03, 8'h00, 8'hA5};
    tbl[6]  = '{1'b0, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{1'b1, 8'h0F, 8'h3C, 8'h00};
    tbl[8]  = '{1'b0, 8'h0F, 8'h00, 8'h3C};
    tbl[9]  = '{1'b1, 8'h10, 8'h77, 8'h00};
    tbl[10] = '{1'b0, 8'h10, 8'h00, 8'hFF};
    tbl[11] = '{1'b0, 8'h00, 8'h00, 8'h00};
    tbl[12] = '{1'b0, 8'h0F, 8'h00, 8'h3C};

    reset_n = 1'b0; sel_en_in = 5'b0; wr_rd_s_in = 1'b0; addr_in = 8'h00; wr_data_in = 8'h00;
    #2;
    chk("reset ack", {31'h0, ack_out}, 0);
    chk("reset rd_data", {24'h0, rd_data_out}, 0);
    chk("reset busy", {31'h0, busy_out}, 0);
    chk("reset xfer_cnt", {24'h0, xfer_cnt_out}, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++) run_xfer(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].exp_rd, $sformatf("vec%0d", i));

    // Select dropped after one wait cycle: aborted write must leave no trace.
    @(negedge clock);
    wr_rd_s_in = 1'b1; addr_in = 8'h03; wr_data_in = 8'h55; sel_en_in = SEL;
    @(negedge clock);
    @(negedge clock);
    chk("abort busy_before_drop", {31'h0, busy_out}, 1);
    sel_en_in = 5'b0;
    @(negedge clock);
    chk("abort busy_cleared", {31'h0, busy_out}, 0);
    count_acks(6, acks, busies);
    chk("abort no_ack", acks, 0);
    chk("abort xfer_cnt", {24'h0, xfer_cnt_out}, {24'h0, exp_cnt});

    // Foreign select bits must be ignored entirely.
    sel_en_in = 5'b00100;
    count_acks(8, acks, busies);
    chk("other_sel no_ack", acks, 0);
    chk("other_sel no_busy", busies, 0);
    sel_en_in = 5'b11110;
    count_acks(8, acks, busies);
    chk("many_sel no_ack", acks, 0);
    chk("many_sel no_busy", busies, 0);
    sel_en_in = 5'b0;
    chk("other_sel xfer_cnt", {24'h0, xfer_cnt_out}, {24'h0, exp_cnt});
    run_xfer(1'b0, 8'h03, 8'h00, 8'hA5, "after_abort rd03");

    // Asynchronous reset in the middle of a write's wait phase.
    @(negedge clock);
    wr_rd_s_in = 1'b1; addr_in = 8'h05; wr_data_in = 8'h99; sel_en_in = SEL;
    @(negedge clock);
    chk("midreset busy_before", {31'h0, busy_out}, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset busy", {31'h0, busy_out}, 0);
    chk("midreset ack", {31'h0, ack_out}, 0);
    chk("midreset rd_data", {24'h0, rd_data_out}, 0);
    chk("midreset xfer_cnt", {24'h0, xfer_cnt_out}, 0);
    exp_cnt = 8'h00;
    @(negedge clock);
    sel_en_in = 5'b0;
    @(negedge clock);
    reset_n = 1'b1;
    count_acks(6, acks, busies);
    chk("midreset no_ack_after", acks, 0);
    run_xfer(1'b0, 8'h05, 8'h00, 8'h00, "midreset rd05");
    run_xfer(1'b0, 8'h03, 8'h00, 8'h00, "midreset rd03");

    // Count wrap: 254 more reads bring the count from 2 around to 0.
    for (int i = 0; i < 254; i++) run_xfer(1'b0, 8'(i), 8'h00, (i < 16) ? 8'h00 : 8'hFF, $sformatf("wrap%0d", i));
    chk("wrap xfer_cnt_zero", {24'h0, xfer_cnt_out}, 0);

    // Select held through two ack windows produces only one ack.
    @(negedge clock);
    wr_rd_s_in = 1'b0; addr_in = 8'h01; sel_en_in = SEL;
    count_acks(2 * (WS + 3), acks, busies);
    chk("held_sel one_ack", acks, 1);
    chk("held_sel busy_all", busies, 2 * (WS + 3));
    sel_en_in = 5'b0;
    @(negedge clock);
    exp_cnt = exp_cnt + 8'd1;
    chk("held_sel xfer_cnt", {24'h0, xfer_cnt_out}, {24'h0, exp_cnt});
    chk("held_sel busy_release", {31'h0, busy_out}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
